// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - 4-digit multiplexed 7-segment scan controller with hex/decimal formatting
module display_scan_ctrl #(
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [7:0] value,
  input  logic [1:0] mode,
  output logic [3:0] nibble,
  output logic [3:0] dig_en_n,
  output logic       blank,
  output logic       neg
);

  typedef enum logic [1:0] {IDLE, CONV, SHOW} state_t;

  // One double-dabble step on {bcd[11:0], bin[7:0]}: add 3 to any BCD digit >= 5, then shift left.
  function automatic logic [19:0] dabble(input logic [19:0] v);
    logic [19:0] r;
    r = v;
    for (int i = 0; i < 3; i++) begin
      if (r[8+4*i +: 4] >= 4'd5) r[8+4*i +: 4] = r[8+4*i +: 4] + 4'd3;
    end
    return {r[18:0], 1'b0};
  endfunction

  state_t     state;
  logic       pend_hex;
  logic       pend_dec;
  logic [7:0] hold;
  logic       neg_hold;
  logic [19:0] acc;
  logic [3:0] step;
  logic [3:0] dig_code [4];
  logic       dig_blank [4];
  logic [CNT_W-1:0] cnt;
  logic [1:0] idx;
  logic       accept;
  logic       is_dec;

  // A decimal load is still pending for one cycle before CONV shows on load_ready; block a second accept then.
  assign accept = load_valid & load_ready & ~pend_dec;
  assign is_dec = (mode == 2'b01) || (mode == 2'b10);

  // Load capture, conversion sequencing and digit register updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      load_ready <= 1'b0;
      pend_hex   <= 1'b0;
      pend_dec   <= 1'b0;
      hold       <= 8'd0;
      neg_hold   <= 1'b0;
      acc        <= 20'd0;
      step       <= 4'd0;
      neg        <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        dig_code[i]  <= 4'd0;
        dig_blank[i] <= 1'b1;
      end
    end else begin
      pend_hex <= 1'b0;
      pend_dec <= 1'b0;
      if (accept) begin
        hold     <= (mode == 2'b10 && value[7]) ? (~value + 8'd1) : value;
        neg_hold <= (mode == 2'b10) && value[7];
        pend_dec <= is_dec;
        pend_hex <= !is_dec;
      end
      case (state)
        IDLE, SHOW: begin
          load_ready <= 1'b1;
          if (pend_hex) begin
            dig_code[0]  <= hold[3:0];
            dig_code[1]  <= hold[7:4];
            dig_code[2]  <= 4'd0;
            dig_code[3]  <= 4'd0;
            dig_blank[0] <= 1'b0;
            dig_blank[1] <= 1'b0;
            dig_blank[2] <= 1'b1;
            dig_blank[3] <= 1'b1;
            neg          <= 1'b0;
            state        <= SHOW;
          end else if (pend_dec) begin
            acc        <= dabble({12'd0, hold});
            step       <= 4'd1;
            load_ready <= 1'b0;
            state      <= CONV;
          end
        end
        CONV: begin
          if (step == 4'd8) begin
            dig_code[0]  <= acc[11:8];
            dig_code[1]  <= acc[15:12];
            dig_code[2]  <= acc[19:16];
            dig_code[3]  <= 4'd0;
            dig_blank[0] <= 1'b0;
            dig_blank[1] <= (acc[19:12] == 8'd0);
            dig_blank[2] <= (acc[19:16] == 4'd0);
            dig_blank[3] <= 1'b1;
            neg          <= neg_hold;
            load_ready   <= 1'b1;
            state        <= SHOW;
          end else begin
            acc  <= dabble(acc);
            step <= step + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Free-running prescaler and scan index, plus registered per-digit outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      idx      <= 2'd0;
      nibble   <= 4'd0;
      dig_en_n <= 4'b1111;
      blank    <= 1'b1;
    end else begin
      if (cnt == CNT_W'(SCAN_DIV - 1)) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      blank    <= dig_blank[idx];
      nibble   <= dig_blank[idx] ? 4'd0 : dig_code[idx];
      dig_en_n <= dig_blank[idx] ? 4'b1111 : ~(4'b0001 << idx);
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - self-checking bench for display_scan_ctrl
module tb_display_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] value;
  logic [1:0] mode;
  logic [3:0] nibble;
  logic [3:0] dig_en_n;
  logic       blank;
  logic       neg;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_code [4];
  logic       exp_blank [4];
  logic       exp_neg;

  display_scan_ctrl #(.SCAN_DIV(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .value(value), .mode(mode), .nibble(nibble), .dig_en_n(dig_en_n),
    .blank(blank), .neg(neg)
  );

  always #5 clk = ~clk;

  // Expected display content from the formatting rules, using plain arithmetic.
  task automatic model(input logic [1:0] m, input logic [7:0] v);
    int mag;
    if (m == 2'b01 || m == 2'b10) begin
      mag = (m == 2'b10 && v >= 8'd128) ? 256 - int'(v) : int'(v);
      exp_code[0]  = 4'(mag % 10);
      exp_code[1]  = 4'((mag / 10) % 10);
      exp_code[2]  = 4'(mag / 100);
      exp_code[3]  = 4'd0;
      exp_blank[0] = 1'b0;
      exp_blank[1] = (mag < 10);
      exp_blank[2] = (mag < 100);
      exp_blank[3] = 1'b1;
      exp_neg      = (m == 2'b10) && (v >= 8'd128);
    end else begin
      exp_code[0]  = 4'(v % 16);
      exp_code[1]  = 4'(v / 16);
      exp_code[2]  = 4'd0;
      exp_code[3]  = 4'd0;
      exp_blank[0] = 1'b0;
      exp_blank[1] = 1'b0;
      exp_blank[2] = 1'b1;
      exp_blank[3] = 1'b1;
      exp_neg      = 1'b0;
    end
  endtask

  task automatic model_dark();
    for (int i = 0; i < 4; i++) begin
      exp_code[i]  = 4'd0;
      exp_blank[i] = 1'b1;
    end
    exp_neg = 1'b0;
  endtask

  // Watch one and a half scan rounds and compare every slot against the model.
  task automatic check_display(input string name);
    bit seen [4];
    int k;
    for (int i = 0; i < 4; i++) seen[i] = 0;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      k = -1;
      case (dig_en_n)
        4'b1110: k = 0;
        4'b1101: k = 1;
        4'b1011: k = 2;
        4'b0111: k = 3;
        default: k = -1;
      endcase
      checks++;
      if (dig_en_n === 4'b1111) begin
        if (blank !== 1'b1 || nibble !== 4'd0) begin
          errors++;
          $display("FAIL %s dark slot: blank=%b nibble=%h, required blank=1 nibble=0", name, blank, nibble);
        end
      end else if (k < 0) begin
        errors++;
        $display("FAIL %s dig_en_n=%b not one-hot low", name, dig_en_n);
      end else begin
        seen[k] = 1;
        if (blank !== 1'b0 || exp_blank[k] || nibble !== exp_code[k]) begin
          errors++;
          $display("FAIL %s digit%0d: blank=%b nibble=%h, required blank=%b nibble=%h",
                   name, k, blank, nibble, exp_blank[k], exp_code[k]);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (seen[i] !== !exp_blank[i]) begin
        errors++;
        $display("FAIL %s digit%0d shown=%0d, required shown=%0d", name, i, seen[i], !exp_blank[i]);
      end
    end
    checks++;
    if (neg !== exp_neg) begin
      errors++;
      $display("FAIL %s neg=%b, required %b", name, neg, exp_neg);
    end
  endtask

  // Present one load, confirm acceptance, and measure how long load_ready stays low.
  task automatic do_load(input logic [1:0] m, input logic [7:0] v, input string name);
    int low;
    int exp_low;
    @(negedge clk);
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before_load=%b, required 1", name, load_ready);
    end
    load_valid = 1'b1;
    value      = v;
    mode       = m;
    @(posedge clk);
    #1 load_valid = 1'b0;
    model(m, v);
    low = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (load_ready === 1'b1) break;
      low++;
    end
    exp_low = (m == 2'b01 || m == 2'b10) ? 8 : 0;
    checks++;
    if (low !== exp_low) begin
      errors++;
      $display("FAIL %s ready_low_cycles=%0d, required %0d", name, low, exp_low);
    end
    check_display(name);
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (nibble !== 4'd0 || dig_en_n !== 4'b1111 || blank !== 1'b1 || neg !== 1'b0 || load_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s nibble=%h dig_en_n=%b blank=%b neg=%b ready=%b, required 0 1111 1 0 0",
               name, nibble, dig_en_n, blank, neg, load_ready);
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    load_valid = 1'b1;
    value      = 8'h42;
    mode       = 2'b00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release ready=%b, required 1", load_ready);
    end
    load_valid = 1'b0;
    model_dark();
    check_display("reset_dark");
  endtask

  task automatic test_directed();
    do_load(2'b00, 8'hA5, "hex_a5");
    do_load(2'b01, 8'd200, "udec_200");
    do_load(2'b01, 8'd7, "udec_7");
    do_load(2'b10, 8'h80, "sdec_80");
    do_load(2'b10, 8'hF6, "sdec_f6");
    do_load(2'b10, 8'h7F, "sdec_7f");
    do_load(2'b11, 8'h09, "mode11_hex");
    do_load(2'b01, 8'd0, "udec_0");
  endtask

  task automatic test_random();
    logic [1:0] m;
    logic [7:0] v;
    for (int n = 0; n < 12; n++) begin
      m = 2'($urandom_range(0, 3));
      v = 8'($urandom_range(0, 255));
      do_load(m, v, $sformatf("rand%0d_m%0d_v%02h", n, m, v));
    end
  endtask

  task automatic test_scan();
    logic [3:0] prev;
    bit found;
    logic [3:0] want_en;
    do_load(2'b00, 8'h3C, "scan_load");
    prev  = dig_en_n;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dig_en_n === 4'b1110 && prev !== 4'b1110) begin
        found = 1;
        break;
      end
      prev = dig_en_n;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL scan_align no 1110 slot start seen, required within 40 cycles");
    end else begin
      for (int c = 0; c < 32; c++) begin
        want_en = ((c % 16) < 4) ? 4'b1110 : ((c % 16) < 8) ? 4'b1101 : 4'b1111;
        checks++;
        if (dig_en_n !== want_en ||
            (want_en == 4'b1110 && nibble !== 4'hC) ||
            (want_en == 4'b1101 && nibble !== 4'h3) ||
            (want_en == 4'b1111 && (blank !== 1'b1 || nibble !== 4'h0))) begin
          errors++;
          $display("FAIL scan_seq c=%0d dig_en_n=%b nibble=%h blank=%b, required dig_en_n=%b",
                   c, dig_en_n, nibble, blank, want_en);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_ignore_during_conv();
    int waited;
    @(negedge clk);
    load_valid = 1'b1;
    value      = 8'd255;
    mode       = 2'b01;
    @(posedge clk);
    #1 load_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (load_ready !== 1'b0) begin
      errors++;
      $display("FAIL conv_busy ready=%b, required 0", load_ready);
    end
    load_valid = 1'b1;
    value      = 8'h11;
    mode       = 2'b00;
    @(negedge clk);
    load_valid = 1'b0;
    waited = 0;
    while (load_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (waited >= 20) begin
      errors++;
      $display("FAIL conv_timeout ready=%b, required 1 within 20 cycles", load_ready);
    end
    model(2'b01, 8'd255);
    check_display("ignore_pulse_255");
  endtask

  task automatic test_reset_during_conv();
    @(negedge clk);
    load_valid = 1'b1;
    value      = 8'd123;
    mode       = 2'b10;
    @(posedge clk);
    #1 load_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("abort_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_release ready=%b, required 1", load_ready);
    end
    model_dark();
    check_display("abort_dark");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_scan();
    test_ignore_during_conv();
    test_reset_during_conv();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Drives a 4-digit multiplexed 7-segment display from one shared hex digit decoder.
- Accepts an 8-bit ALU/RPN result through a valid/ready handshake.
- Formats the result as hex, unsigned decimal or signed decimal. Decimal conversion is a sequential double-dabble.
- Time-multiplexes the four digit nibbles onto the decoder inputs and drives the per-digit enables.

Parameters:
- SCAN_DIV, 50000, clock cycles each digit stays enabled (minimum 2).
- CNT_W, 16, prescaler width; must satisfy 2^CNT_W >= SCAN_DIV.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- LOAD_VALID  input  1  VALUE/MODE presented for capture.
- LOAD_READY  output  1  block can accept a load.
- VALUE  input  8  result to display.
- MODE  input  2  format select: 00 hex, 01 unsigned decimal, 10 signed decimal, 11 treated as hex.
- NIBBLE  output  4  digit code to the shared decoder (bit3 = MSB, decoder input A).
- DIG_EN_N  output  4  active-low one-hot digit enable; bit0 = rightmost digit.
- BLANK  output  1  high when the currently scanned digit is suppressed.
- NEG  output  1  drives the external minus indicator in signed mode.

Behaviour:
- Reset is asynchronous on RST_N low.
  - Outputs: NIBBLE=0, DIG_EN_N=4'b1111, BLANK=1, NEG=0, LOAD_READY=0.
  - Internal: state=IDLE, prescaler=0, scan index=0, all four digit registers blanked.
  - LOAD_READY goes to 1 on the first edge after RST_N is released.
- States:
  - IDLE: nothing loaded; display dark; LOAD_READY=1.
  - CONV: decimal conversion in progress; LOAD_READY=0.
  - SHOW: displaying the last result; LOAD_READY=1.
- Load handshake:
  - A transfer occurs on the edge where LOAD_VALID=1 and LOAD_READY=1. VALUE and MODE are captured on that edge.
  - LOAD_VALID is ignored while LOAD_READY=0. Nothing is queued.
- Hex load accepted at edge t:
  - The digit registers are updated at edge t+1 and the state is SHOW.
  - Digit0 = VALUE[3:0], digit1 = VALUE[7:4]. Both are always shown, including leading zero.
  - Digits 2 and 3 are blanked. NEG=0.
- Decimal load accepted at edge t:
  - The state enters CONV at t+1 and stays there for exactly 8 cycles, one double-dabble shift/add-3 step per cycle.
  - The digit registers, NEG and the return to SHOW all update at edge t+9.
  - During CONV the display keeps showing the previous digits.
- Decimal operand:
  - Unsigned mode (01): the operand is VALUE.
  - Signed mode (10) with VALUE[7]=1: the operand is the two's-complement negation, NEG=1. 0x80 gives 128.
  - Otherwise NEG=0.
- Decimal digit layout: digit0 = units, digit1 = tens, digit2 = hundreds, digit3 always blanked.
- Leading-zero suppression:
  - Hundreds is blanked when it is 0.
  - Tens is blanked when hundreds and tens are both 0.
  - Units is always shown, so a value of 0 displays "0".
- Scan:
  - The prescaler counts 0..SCAN_DIV-1 continuously in every state.
  - At the terminal count it wraps to 0 and the scan index advances 0→1→2→3→0.
- Scan outputs are registered one cycle after the index changes:
  - NIBBLE = code of the indexed digit register.
  - BLANK = suppression flag of that register.
  - DIG_EN_N = all ones if BLANK, else one-hot low at the index.
  - NIBBLE is forced to 0 when BLANK=1.
- A new load does not reset the prescaler or the scan index. Digit content changes mid-scan are allowed.
- RST_N asserted during CONV aborts the conversion: the state returns to IDLE and the display goes dark. The partial result is discarded.
- After reset, simultaneous LOAD_VALID and RST_N release are ignored until LOAD_READY=1.

Test Plan:
- MODE=00, VALUE=0xA5 → after 1 cycle in SHOW: digit0 NIBBLE=5, digit1 NIBBLE=A, digits 2/3 BLANK=1 with DIG_EN_N=1111 in their slots, NEG=0.
- MODE=01, VALUE=200 → LOAD_READY low for exactly 8 cycles; then digits 0/1/2 = 0/0/2 and digit3 blanked. VALUE=7 → units 7, tens and hundreds blanked.
- MODE=10, VALUE=0x80 → 1/2/8 on digits 2/1/0, NEG=1. VALUE=0xF6 → tens 1, units 0, hundreds blanked, NEG=1. VALUE=0x7F → 127, NEG=0.
- SCAN_DIV=4, hex 0x3C loaded → DIG_EN_N sequence 1110 (4 cycles), 1101 (4), 1111 (8), repeating; NIBBLE C then 3.
- Decimal load of 255, then LOAD_VALID pulsed with 0x11 during CONV → pulse ignored; display shows 255 at t+9.
- RST_N pulsed low at CONV cycle 4 → all outputs at reset values immediately; LOAD_READY=1 one edge after release; display stays dark until the next load.
